// File: rtl/fire_zone_controller.sv
// fire_zone_controller
//   Multi-zone fire confirmation and extinguisher sequencer. Each zone watches
//   fire = smoke & heat. A zone discharges only after CONFIRM_CYCLES
//   consecutive armed fire samples. It then drives its valve for exactly
//   DISCHARGE_CYCLES cycles and holds its alarm until an operator ack arrives
//   while its fire input is low.
//
// Ports
//   clk               in   1      system clock, rising edge
//   rst               in   1      asynchronous, active-high reset
//   zone_en           in   ZONES  per-zone arm enable
//   smoke             in   ZONES  smoke present per zone
//   heat              in   ZONES  over-temperature flag per zone
//   ack               in   1      global operator acknowledge (level)
//   fire_extinguisher out  ZONES  valve drive, high while discharging
//   zone_alarm        out  ZONES  high while discharging or latched
//   alarm             out  1      OR of zone_alarm
//   discharge_count   out  EVT_W  saturating count of discharge events
module fire_zone_controller #(
  parameter int ZONES            = 4,
  parameter int CONFIRM_CYCLES   = 8,
  parameter int DISCHARGE_CYCLES = 16,
  parameter int EVT_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ZONES-1:0] zone_en,
  input  logic [ZONES-1:0] smoke,
  input  logic [ZONES-1:0] heat,
  input  logic             ack,
  output logic [ZONES-1:0] fire_extinguisher,
  output logic [ZONES-1:0] zone_alarm,
  output logic             alarm,
  output logic [EVT_W-1:0] discharge_count
);

  localparam int MAX_CYC = (CONFIRM_CYCLES > DISCHARGE_CYCLES) ? CONFIRM_CYCLES
                                                                : DISCHARGE_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int ZW = $clog2(ZONES + 1);
  localparam int SW = EVT_W + ZW;

  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [CW-1:0] DIS_LAST  = CW'(DISCHARGE_CYCLES - 1);
  localparam logic [SW-1:0] EVT_MAX   = {{ZW{1'b0}}, {EVT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_DISCHARGE,
    S_LATCHED
  } state_t;

  state_t          state_q [ZONES];
  state_t          state_d [ZONES];
  logic [CW-1:0]   cnt_q   [ZONES];
  logic [CW-1:0]   cnt_d   [ZONES];
  logic [ZONES-1:0] fire;
  logic [ZW-1:0]   entering;
  logic [SW-1:0]   evt_sum;

  assign fire = smoke & heat;

  always_comb begin
    entering = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      state_d[z] = state_q[z];
      cnt_d[z]   = cnt_q[z];
      unique case (state_q[z])
        S_IDLE: begin
          if (zone_en[z] && fire[z]) begin
            if (CONFIRM_CYCLES == 1) begin
              state_d[z] = S_DISCHARGE;
              cnt_d[z]   = '0;
            end else begin
              state_d[z] = S_CONFIRM;
              cnt_d[z]   = CW'(1);
            end
          end
        end
        S_CONFIRM: begin
          if (!zone_en[z] || !fire[z]) begin
            state_d[z] = S_IDLE;
            cnt_d[z]   = '0;
          end else if (cnt_q[z] == CONF_LAST) begin
            state_d[z] = S_DISCHARGE;
            cnt_d[z]   = '0;
          end else begin
            cnt_d[z] = cnt_q[z] + CW'(1);
          end
        end
        S_DISCHARGE: begin
          if (cnt_q[z] == DIS_LAST) begin
            state_d[z] = S_LATCHED;
            cnt_d[z]   = '0;
          end else begin
            cnt_d[z] = cnt_q[z] + CW'(1);
          end
        end
        S_LATCHED: begin
          if (ack && !fire[z]) begin
            state_d[z] = S_IDLE;
          end
        end
        default: begin
          state_d[z] = S_IDLE;
          cnt_d[z]   = '0;
        end
      endcase
      if (state_q[z] != S_DISCHARGE && state_d[z] == S_DISCHARGE) begin
        entering = entering + ZW'(1);
      end
    end
    // Extra headroom bits so several simultaneous entries cannot wrap before saturation.
    evt_sum = {{ZW{1'b0}}, discharge_count} + SW'(entering);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned z = 0; z < ZONES; z++) begin
        state_q[z] <= S_IDLE;
        cnt_q[z]   <= '0;
      end
      discharge_count <= '0;
    end else begin
      for (int unsigned z = 0; z < ZONES; z++) begin
        state_q[z] <= state_d[z];
        cnt_q[z]   <= cnt_d[z];
      end
      if (evt_sum > EVT_MAX) begin
        discharge_count <= '1;
      end else begin
        discharge_count <= evt_sum[EVT_W-1:0];
      end
    end
  end

  always_comb begin
    fire_extinguisher = '0;
    zone_alarm        = '0;
    for (int unsigned z = 0; z < ZONES; z++) begin
      fire_extinguisher[z] = (state_q[z] == S_DISCHARGE);
      zone_alarm[z]        = (state_q[z] == S_DISCHARGE) || (state_q[z] == S_LATCHED);
    end
  end

  assign alarm = |zone_alarm;

endmodule

// File: tb/tb_fire_zone_controller.sv
module tb_fire_zone_controller;

  localparam int Z  = 4;
  localparam int CC = 8;
  localparam int DC = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [Z-1:0] zone_en = '1;
  logic [Z-1:0] smoke = '0;
  logic [Z-1:0] heat = '0;
  logic         ack = 1'b0;

  logic [Z-1:0] ext1, za1, ext2, za2;
  logic         al1, al2;
  logic [7:0]   cnt1;
  logic [1:0]   cnt2;

  fire_zone_controller #(
    .ZONES(Z), .CONFIRM_CYCLES(CC), .DISCHARGE_CYCLES(DC), .EVT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .zone_en(zone_en), .smoke(smoke), .heat(heat),
    .ack(ack), .fire_extinguisher(ext1), .zone_alarm(za1), .alarm(al1),
    .discharge_count(cnt1)
  );

  fire_zone_controller #(
    .ZONES(Z), .CONFIRM_CYCLES(CC), .DISCHARGE_CYCLES(DC), .EVT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .zone_en(zone_en), .smoke(smoke), .heat(heat),
    .ack(ack), .fire_extinguisher(ext2), .zone_alarm(za2), .alarm(al2),
    .discharge_count(cnt2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  string phase = "reset";

  // Reference model: consecutive armed-fire run length, remaining discharge
  // time, and an alarm latch per zone, plus a total event tally.
  int run   [Z];
  int dleft [Z];
  bit lat   [Z];
  int events;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < Z; z++) begin
      run[z] = 0; dleft[z] = 0; lat[z] = 0;
    end
    events = 0;
  endtask

  task automatic model_edge();
    for (int z = 0; z < Z; z++) begin
      bit f;
      f = smoke[z] & heat[z];
      if (dleft[z] > 0) begin
        dleft[z]--;
        if (dleft[z] == 0) lat[z] = 1;
      end else if (lat[z]) begin
        if (ack && !f) lat[z] = 0;
      end else if (zone_en[z] && f) begin
        run[z]++;
        if (run[z] >= CC) begin
          dleft[z] = DC;
          run[z]   = 0;
          events++;
        end
      end else begin
        run[z] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [Z-1:0] e_ext, e_za;
    for (int z = 0; z < Z; z++) begin
      e_ext[z] = (dleft[z] > 0);
      e_za[z]  = (dleft[z] > 0) || lat[z];
    end
    chk("ext",   ext1, e_ext);
    chk("zalm",  za1,  e_za);
    chk("alarm", al1,  |e_za);
    chk("count", cnt1, (events > 255) ? 255 : events);
    chk("ext_s", ext2, e_ext);
    chk("zalm_s", za2, e_za);
    chk("alarm_s", al2, |e_za);
    chk("count_s", cnt2, (events > 3) ? 3 : events);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic set_fire(input int z, input bit v);
    smoke[z] = v;
    heat[z]  = v;
  endtask

  initial begin
    bit fr [Z];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Interrupted confirmation, then a full confirmation and discharge.
    phase = "t1";
    set_fire(0, 1); repeat (7) step();
    set_fire(0, 0); step();
    chk("no_early", ext1[0], 1'b0);
    set_fire(0, 1); repeat (8) step();
    chk("ext_on", ext1[0], 1'b1);
    chk("count1", cnt1, 8'd1);
    set_fire(0, 0); repeat (15) step();
    chk("ext_last", ext1[0], 1'b1);
    step();
    chk("ext_off", ext1[0], 1'b0);
    chk("latched", za1[0], 1'b1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("cleared", al1, 1'b0);

    // Smoke without heat never qualifies.
    phase = "t2";
    smoke[1] = 1'b1;
    repeat (100) step();
    chk("alarm_quiet", al1, 1'b0);
    smoke[1] = 1'b0;

    // Two zones confirmed on the same edge.
    phase = "t3";
    set_fire(1, 1); set_fire(2, 1);
    repeat (7) step();
    chk("count_pre", cnt1, 8'd1);
    step();
    chk("count_jump", cnt1, 8'd3);
    chk("both_ext", ext1[2:1], 2'b11);

    // Ack ignored during discharge and while fire persists.
    phase = "t4";
    repeat (4) step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_ign", ext1[2:1], 2'b11);
    repeat (11) step();
    chk("latch12", za1[2:1], 2'b11);
    chk("ext12_off", ext1[2:1], 2'b00);
    ack = 1'b1; step(); ack = 1'b0;
    chk("hold_fire", za1[2:1], 2'b11);
    set_fire(1, 0); set_fire(2, 0); step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_clear", za1, 4'b0000);

    // Disarm during confirm aborts; disarm during discharge does not.
    phase = "t5";
    set_fire(3, 1); repeat (5) step();
    zone_en[3] = 1'b0; step();
    zone_en[3] = 1'b1; repeat (7) step();
    chk("abort", ext1[3], 1'b0);
    step();
    chk("z3_on", ext1[3], 1'b1);
    zone_en[3] = 1'b0; repeat (15) step();
    chk("z3_full", ext1[3], 1'b1);
    step();
    chk("z3_done", ext1[3], 1'b0);
    zone_en[3] = 1'b1; set_fire(3, 0);
    ack = 1'b1; step(); ack = 1'b0;

    // Asynchronous reset in the middle of a discharge.
    phase = "t6";
    set_fire(0, 1); repeat (10) step();
    chk("pre_rst", ext1[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_ext", ext1, 4'b0000);
    set_fire(0, 0);
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // Randomized phase: persistent per-zone fire episodes with noise.
    phase = "rand";
    for (int z = 0; z < Z; z++) fr[z] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int z = 0; z < Z; z++) begin
        if ($urandom_range(0, 15) == 0) fr[z] = ~fr[z];
        heat[z]    = fr[z] | ($urandom_range(0, 7) == 0);
        smoke[z]   = fr[z];
        zone_en[z] = ($urandom_range(0, 31) != 0);
      end
      ack = ($urandom_range(0, 7) == 0);
      step();
    end
    chk("sat_total", cnt2, (events > 3) ? 3 : events);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
